cache_valid_sequencer: RTL

//  Owns the single write port of one cache valid-bit array. Arbitrates that port

---
 rtl/cache_valid_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/cache_valid_sequencer.sv
// cache_valid_sequencer
//   Owns the single write port of a cache valid-bit array. Line fills set a
//   valid bit, single-line invalidates clear one, and a flush-all sweep clears
//   every set at one set per clock. Tag lookups stall while the sweep runs.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   flush_all_req              sweep request (a pulse is enough)
//   flush_all_busy             sweep in progress (registered)
//   flush_all_done             one-cycle pulse after the last sweep write
//   lookup_stall               same as flush_all_busy
//   fill_en/fill_set/fill_ack  fill request; held until acked
//   inval_en/inval_set/inval_ack  invalidate request; held until acked
//   va_wr_enable/va_wr_addr/va_wr_is_valid  valid array write port
module cache_valid_sequencer #(
    parameter int NUM_SETS   = 32,
    parameter int ADDR_WIDTH = $clog2(NUM_SETS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_all_req,
    output logic                  flush_all_busy,
    output logic                  flush_all_done,
    output logic                  lookup_stall,
    input  logic                  fill_en,
    input  logic [ADDR_WIDTH-1:0] fill_set,
    output logic                  fill_ack,
    input  logic                  inval_en,
    input  logic [ADDR_WIDTH-1:0] inval_set,
    output logic                  inval_ack,
    output logic                  va_wr_enable,
    output logic [ADDR_WIDTH-1:0] va_wr_addr,
    output logic                  va_wr_is_valid
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(NUM_SETS - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] counter, counter_next;
    logic                  sweep_last;

    assign sweep_last     = (state == SWEEP) && (counter == LAST_SET);
    assign flush_all_busy = (state == SWEEP);
    assign lookup_stall   = flush_all_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            counter        <= '0;
            flush_all_done <= 1'b0;
        end else begin
            state          <= state_next;
            counter        <= counter_next;
            // Done lands the cycle after the final sweep write, when busy has dropped.
            flush_all_done <= sweep_last;
        end
    end

    always_comb begin
        state_next     = state;
        counter_next   = counter;
        fill_ack       = 1'b0;
        inval_ack      = 1'b0;
        va_wr_enable   = 1'b0;
        va_wr_addr     = '0;
        va_wr_is_valid = 1'b0;

        case (state)
            IDLE: begin
                if (flush_all_req) begin
                    state_next   = SWEEP;
                    counter_next = '0;
                end
                // Invalidate wins over fill; a same-set fill simply retries next cycle.
                if (inval_en) begin
                    inval_ack    = 1'b1;
                    va_wr_enable = 1'b1;
                    va_wr_addr   = inval_set;
                end else if (fill_en) begin
                    fill_ack       = 1'b1;
                    va_wr_enable   = 1'b1;
                    va_wr_addr     = fill_set;
                    va_wr_is_valid = 1'b1;
                end
            end
            SWEEP: begin
                va_wr_enable = 1'b1;
                va_wr_addr   = counter;
                // The sweep clears every set anyway, so invalidates complete for free.
                // Fills are held off so nothing becomes valid behind the sweep.
                inval_ack    = inval_en;
                counter_next = counter + 1'b1;
                if (sweep_last) begin
                    state_next = IDLE;
                end
                // flush_all_req is coalesced into the running sweep.
            end
            default: state_next = IDLE;
        endcase

        // Nothing reaches the array or the requesters while reset is held.
        if (reset) begin
            fill_ack     = 1'b0;
            inval_ack    = 1'b0;
            va_wr_enable = 1'b0;
        end
    end

endmodule
